// File: rtl/font_render_scheduler_pkg.sv
// font_render_scheduler_pkg: shared text-screen geometry, cell/glyph types and scheduler states
// Exports: screen/cell constants, SramAddress_t, CharGrid_t, TextCell_t, SchedState_t
package font_render_scheduler_pkg;
    localparam int TEXT_COLUMNS    = 80;
    localparam int TEXT_ROWS       = 30;
    localparam int CELL_W          = 8;
    localparam int CELL_H          = 16;
    localparam int GLYPH_BITS      = CELL_W * CELL_H;
    localparam int SRAM_AW         = 20;
    localparam int CELL_STRIDE_ROW = TEXT_COLUMNS * CELL_W * CELL_H;

    typedef logic [SRAM_AW-1:0] SramAddress_t;

    typedef struct packed {
        logic [GLYPH_BITS-1:0] shape;
        logic [3:0]            fg;
        logic [3:0]            bg;
    } CharGrid_t;

    typedef struct packed {
        logic [7:0] code;
        logic [3:0] fg;
        logic [3:0] bg;
    } TextCell_t;

    typedef enum logic [3:0] {
        IDLE, READ_TEXT, READ_FONT, LOAD, WAIT_IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, FINISH
    } SchedState_t;
endpackage

// File: rtl/font_render_scheduler_cell.sv
// cell_address_gen: row-major cell walker with incremental framebuffer address
// Ports: clk, rst (async active-low), clear (restart at cell 0 and latch frameBase),
//        advance (step one cell), cellIndex (row*COLUMNS+col), cellBase (framebuffer base
//        of the current cell), lastCell (current cell is the final one of the screen)
module cell_address_gen
    import font_render_scheduler_pkg::*;
#(
    parameter int COLUMNS = TEXT_COLUMNS,
    parameter int ROWS    = TEXT_ROWS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         advance,
    input  SramAddress_t frameBase,
    output logic [11:0]  cellIndex,
    output SramAddress_t cellBase,
    output logic         lastCell
);
    localparam int CW = $clog2(COLUMNS);
    localparam int RW = $clog2(ROWS);
    localparam SramAddress_t ROW_STRIDE = SramAddress_t'(COLUMNS * CELL_W * CELL_H);
    localparam SramAddress_t COL_STRIDE = SramAddress_t'(CELL_W);
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    SramAddress_t  base, rowOffset, colOffset;
    logic          lastCol;
    assign lastCol  = col == CW'(COLUMNS - 1);
    assign lastCell = lastCol && row == RW'(ROWS - 1);
    // Row offset is accumulated rather than multiplied; wrap-around is intentional.
    assign cellBase = base + rowOffset + colOffset;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            col       <= '0;
            row       <= '0;
            base      <= '0;
            rowOffset <= '0;
            colOffset <= '0;
            cellIndex <= '0;
        end else if (clear) begin
            col       <= '0;
            row       <= '0;
            base      <= frameBase;
            rowOffset <= '0;
            colOffset <= '0;
            cellIndex <= '0;
        end else if (advance) begin
            cellIndex <= cellIndex + 12'd1;
            col       <= lastCol ? '0 : col + 1'b1;
            colOffset <= lastCol ? '0 : colOffset + COL_STRIDE;
            row       <= lastCol ? row + 1'b1 : row;
            rowOffset <= lastCol ? rowOffset + ROW_STRIDE : rowOffset;
        end
endmodule

// File: rtl/font_render_scheduler.sv
// font_render_scheduler: walks the text screen cell by cell, fetches glyphs and launches the renderer
// Ports: clk, rst (async active-low), start/frameBase (sweep request), textAddress/textData
//        (text buffer, 1-cycle read), fontAddress/fontShape (font ROM, 1-cycle read),
//        grid/baseAddress/fontReady/rendererDone (renderer handshake), busy, frameDone
module font_render_scheduler
    import font_render_scheduler_pkg::*;
#(
    parameter int COLUMNS = TEXT_COLUMNS,
    parameter int ROWS    = TEXT_ROWS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  SramAddress_t          frameBase,
    output logic [11:0]           textAddress,
    input  TextCell_t             textData,
    output logic [7:0]            fontAddress,
    input  logic [GLYPH_BITS-1:0] fontShape,
    output CharGrid_t             grid,
    output SramAddress_t          baseAddress,
    output logic                  fontReady,
    input  logic                  rendererDone,
    output logic                  busy,
    output logic                  frameDone
);
    SchedState_t  state;
    logic         pending, clear, advance, lastCell;
    logic [3:0]   fg, bg;
    logic [7:0]   fontCode;
    SramAddress_t cellBase;
    assign clear   = (state == IDLE && start) || (state == FINISH && (pending || start));
    assign advance = state == WAIT_DONE && rendererDone && !lastCell;
    // The ROM sees the glyph code in the same cycle textData arrives; afterwards it holds.
    assign fontAddress = state == READ_FONT ? textData.code : fontCode;
    cell_address_gen #(.COLUMNS(COLUMNS), .ROWS(ROWS)) addrGen (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .advance  (advance),
        .frameBase(frameBase),
        .cellIndex(textAddress),
        .cellBase (cellBase),
        .lastCell (lastCell)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state       <= IDLE;
            pending     <= 1'b0;
            fontReady   <= 1'b0;
            busy        <= 1'b0;
            frameDone   <= 1'b0;
            grid        <= '0;
            baseAddress <= '0;
            fg          <= '0;
            bg          <= '0;
            fontCode    <= '0;
        end else begin
            fontReady <= 1'b0;
            frameDone <= 1'b0;
            // A start in FINISH restarts directly, so only earlier requests are parked.
            if (start && state != IDLE && state != FINISH) pending <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    state <= READ_TEXT;
                    busy  <= 1'b1;
                end
                READ_TEXT: state <= READ_FONT;
                READ_FONT: begin
                    fg       <= textData.fg;
                    bg       <= textData.bg;
                    fontCode <= textData.code;
                    state    <= LOAD;
                end
                LOAD: begin
                    grid        <= {fontShape, fg, bg};
                    baseAddress <= cellBase;
                    state       <= WAIT_IDLE;
                end
                WAIT_IDLE: if (rendererDone) begin
                    state     <= LAUNCH;
                    fontReady <= 1'b1;
                end
                LAUNCH: state <= WAIT_ACK;
                WAIT_ACK: if (!rendererDone) state <= WAIT_DONE;
                WAIT_DONE: if (rendererDone) begin
                    state     <= lastCell ? FINISH : READ_TEXT;
                    frameDone <= lastCell;
                end
                FINISH: begin
                    state   <= pending || start ? READ_TEXT : IDLE;
                    busy    <= pending || start;
                    pending <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_font_render_scheduler.sv
// tb_font_render_scheduler: randomized self-checking bench for a 2x2 and a full 80x30 scheduler
module tb_font_render_scheduler;
    import font_render_scheduler_pkg::*;
    localparam int SC = 2, SR = 2, FC = 80, FR = 30;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    logic [15:0] textMem [0:4095];
    int nChecks = 0, nFails = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [GLYPH_BITS-1:0] shapeOf(input logic [7:0] c);
        return {16{c}} ^ {4{32'h9E3779B9}};
    endfunction

    function automatic CharGrid_t gridOf(input int k);
        logic [15:0] t;
        t = textMem[k];
        return {shapeOf(t[15:8]), t[7:4], t[3:0]};
    endfunction

    // small-screen instance
    logic sStart, sReady, sRdone, sRdoneRaw, sForceLow, sBusy, sFrameDone;
    SramAddress_t sBase, sBaseAddr;
    logic [11:0] sTextAddr;
    logic [7:0] sFontAddr;
    TextCell_t sTextData;
    logic [GLYPH_BITS-1:0] sFontShape;
    CharGrid_t sGrid;
    int sCnt;
    assign sRdone = sRdoneRaw & ~sForceLow;
    font_render_scheduler #(.COLUMNS(SC), .ROWS(SR)) dutS (
        .clk(clk), .rst(rst), .start(sStart), .frameBase(sBase), .textAddress(sTextAddr),
        .textData(sTextData), .fontAddress(sFontAddr), .fontShape(sFontShape), .grid(sGrid),
        .baseAddress(sBaseAddr), .fontReady(sReady), .rendererDone(sRdone), .busy(sBusy),
        .frameDone(sFrameDone)
    );

    // full-screen instance
    logic fStart, fReady, fRdone, fBusy, fFrameDone;
    SramAddress_t fBase, fBaseAddr;
    logic [11:0] fTextAddr;
    logic [7:0] fFontAddr;
    TextCell_t fTextData;
    logic [GLYPH_BITS-1:0] fFontShape;
    CharGrid_t fGrid;
    int fCnt;
    font_render_scheduler #(.COLUMNS(FC), .ROWS(FR)) dutF (
        .clk(clk), .rst(rst), .start(fStart), .frameBase(fBase), .textAddress(fTextAddr),
        .textData(fTextData), .fontAddress(fFontAddr), .fontShape(fFontShape), .grid(fGrid),
        .baseAddress(fBaseAddr), .fontReady(fReady), .rendererDone(fRdone), .busy(fBusy),
        .frameDone(fFrameDone)
    );

    // memories with one-cycle read latency
    always @(posedge clk) begin
        sTextData  <= textMem[sTextAddr];
        sFontShape <= shapeOf(sFontAddr);
        fTextData  <= textMem[fTextAddr];
        fFontShape <= shapeOf(fFontAddr);
    end

    // renderers: done drops for a fixed window after each launch
    always @(posedge clk or negedge rst)
        if (!rst) begin
            sCnt <= 0; sRdoneRaw <= 1'b1; fCnt <= 0; fRdone <= 1'b1;
        end else begin
            if (sReady) begin sCnt <= 10; sRdoneRaw <= 1'b0; end
            else if (sCnt > 0) begin sCnt <= sCnt - 1; sRdoneRaw <= sCnt == 1; end
            if (fReady) begin fCnt <= 1; fRdone <= 1'b0; end
            else if (fCnt > 0) begin fCnt <= fCnt - 1; fRdone <= fCnt == 1; end
        end

    // reference: each sweep visits cells in row-major order from its own base
    SramAddress_t sBaseQ[$];
    SramAddress_t sCur, sExpAddr, sLastAddr, fSweepBase, fLastAddr, fExpAddr;
    CharGrid_t sExpGrid, sLastGrid;
    int sK = 0, sPulses = 0, sFrames = 0, fK = 0, fPulses = 0, fFrames = 0;
    logic sHoldChk = 1'b0;
    always @(negedge clk)
        if (!rst) begin
            sK = 0; sHoldChk = 1'b0; fK = 0;
        end else begin
            if (sHoldChk) begin
                check("s_hold_grid", 160'(sGrid), 160'(sLastGrid));
                check("s_hold_addr", 160'(sBaseAddr), 160'(sLastAddr));
                sHoldChk = 1'b0;
            end
            if (sReady) begin
                if (sK == 0) begin
                    check("s_sweep_expected", 160'(sBaseQ.size() > 0), 160'(1));
                    sCur = sBaseQ.size() > 0 ? sBaseQ.pop_front() : '0;
                end
                sExpAddr = sCur + SramAddress_t'((sK / SC) * SC * 128 + (sK % SC) * 8);
                sExpGrid = gridOf(sK);
                check("s_base", 160'(sBaseAddr), 160'(sExpAddr));
                check("s_grid", 160'(sGrid), 160'(sExpGrid));
                sLastAddr = sExpAddr; sLastGrid = sExpGrid; sHoldChk = 1'b1;
                sK++; sPulses++;
            end
            if (sFrameDone) begin
                check("s_cells_per_frame", 160'(sK), 160'(SC * SR));
                sK = 0; sFrames++;
            end
            if (fReady) begin
                fExpAddr = fSweepBase + SramAddress_t'((fK / FC) * FC * 128 + (fK % FC) * 8);
                check("f_base", 160'(fBaseAddr), 160'(fExpAddr));
                check("f_grid", 160'(fGrid), 160'(gridOf(fK)));
                fLastAddr = fBaseAddr; fK++; fPulses++;
            end
            if (fFrameDone) begin fFrames++; fK = 0; end
        end

    task automatic pulseS(input SramAddress_t b);
        @(negedge clk); sStart = 1'b1; sBase = b;
        @(negedge clk); sStart = 1'b0;
    endtask

    task automatic waitFrameS(input string tag);
        bit seen = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            seen = sFrameDone;
        end
        if (!seen) check(tag, 160'(0), 160'(1));
    endtask

    task automatic waitReadyS(input int n);
        int seen = 0;
        for (int i = 0; i < 300 && seen < n; i++) begin
            @(negedge clk);
            if (sReady) seen++;
        end
        if (seen < n) check("s_ready_timeout", 160'(seen), 160'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, f0;
        SramAddress_t b;
        rst = 1'b0; sStart = 1'b0; fStart = 1'b0; sBase = '0; fBase = '0; sForceLow = 1'b0;
        for (int i = 0; i < 4096; i++) textMem[i] = 16'($urandom);
        textMem[0][15:8] = 8'h41;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 160'({sBusy, sReady, sFrameDone, fBusy, fReady, fFrameDone}), 160'(0));
        check("reset_addr", 160'({sTextAddr, sFontAddr, sBaseAddr}), 160'(0));
        check("reset_grid", 160'(sGrid), 160'(0));
        rst = 1'b1;

        // basic sweep with launch latency
        b = SramAddress_t'($urandom);
        sBaseQ.push_back(b);
        pulseS(b);
        check("s_busy_after_start", 160'(sBusy), 160'(1));
        repeat (3) @(negedge clk);
        check("s_no_early_launch", 160'(sReady), 160'(0));
        @(negedge clk);
        check("s_launch_latency", 160'(sReady), 160'(1));
        waitFrameS("s_frame1_timeout");
        @(negedge clk);
        check("s_pulses_frame1", 160'(sPulses), 160'(4));
        check("s_frames_frame1", 160'(sFrames), 160'(1));
        check("s_idle_after_frame", 160'(sBusy), 160'(0));

        // merged requests while busy; base sampled at restart
        p0 = sPulses; f0 = sFrames;
        sBaseQ.push_back(20'h0); sBaseQ.push_back(20'h9600);
        pulseS(20'h0);
        waitReadyS(2);
        pulseS(20'h5555);
        pulseS(20'h5555);
        sBase = 20'h9600;
        waitFrameS("s_pend_frame_a");
        @(negedge clk);
        check("s_immediate_restart", 160'(sBusy), 160'(1));
        waitFrameS("s_pend_frame_b");
        repeat (40) @(negedge clk);
        check("s_single_extra_sweep", 160'(sFrames - f0), 160'(2));
        check("s_pend_pulses", 160'(sPulses - p0), 160'(8));
        check("s_pend_idle", 160'(sBusy), 160'(0));

        // start in the FINISH cycle
        f0 = sFrames;
        b = SramAddress_t'($urandom);
        sBaseQ.push_back(b); sBaseQ.push_back(b + 20'h100);
        pulseS(b);
        waitFrameS("s_fin_frame_a");
        sStart = 1'b1; sBase = b + 20'h100;
        @(negedge clk); sStart = 1'b0;
        check("s_finish_restart", 160'(sBusy), 160'(1));
        waitFrameS("s_fin_frame_b");
        repeat (40) @(negedge clk);
        check("s_finish_frames", 160'(sFrames - f0), 160'(2));

        // renderer busy across reset release
        rst = 1'b0; sForceLow = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        b = SramAddress_t'($urandom);
        sBaseQ.delete(); sBaseQ.push_back(b);
        p0 = sPulses;
        pulseS(b);
        repeat (20) @(negedge clk);
        check("s_stuck_no_launch", 160'(sPulses - p0), 160'(0));
        check("s_stuck_busy", 160'(sBusy), 160'(1));
        sForceLow = 1'b0;
        repeat (3) @(negedge clk);
        check("s_stuck_single_launch", 160'(sPulses - p0), 160'(1));
        waitFrameS("s_stuck_frame");

        // reset while waiting for the renderer
        sBaseQ.push_back(b ^ 20'h0F0F0);
        pulseS(b ^ 20'h0F0F0);
        waitReadyS(1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("s_rst_ctrl", 160'({sBusy, sReady}), 160'(0));
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        b = SramAddress_t'($urandom);
        sBaseQ.delete(); sBaseQ.push_back(b);
        p0 = sPulses;
        pulseS(b);
        waitFrameS("s_rst_frame");
        @(negedge clk);
        check("s_rst_pulses", 160'(sPulses - p0), 160'(4));

        // full screen
        b = SramAddress_t'($urandom_range(0, 20'h3FFFF));
        fSweepBase = b;
        @(negedge clk); fStart = 1'b1; fBase = b;
        @(negedge clk); fStart = 1'b0;
        for (int i = 0; i < 30000 && fFrames == 0; i++) @(negedge clk);
        @(negedge clk);
        check("f_frames", 160'(fFrames), 160'(1));
        check("f_pulses", 160'(fPulses), 160'(2400));
        check("f_last_base", 160'(fLastAddr), 160'(b + SramAddress_t'(29 * 10240 + 79 * 8)));
        check("f_idle", 160'(fBusy), 160'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
